// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register slave: bus widths, the transfer
// FSM state type and a helper that sizes the register-bank index.
// No ports (package).
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Index width needed to address n registers; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_regs_bank.sv
// ---------------------------------------------------------------------------
// apb_slave_regs_bank
// NUM_REGS x 32-bit register storage with one synchronous write port and
// one asynchronous (combinational) read port. Asynchronously cleared to 0.
//
// Ports:
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous active-low reset
//   i_we     in   write enable (caller guarantees i_waddr is in range)
//   i_waddr  in   write index
//   i_wdata  in   write data
//   i_raddr  in   read index
//   o_rdata  out  contents of the register at i_raddr
// ---------------------------------------------------------------------------
module apb_slave_regs_bank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = idx_width(NUM_REGS)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [APB_DATA_W-1:0] o_rdata
);

    logic [APB_DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // For non-power-of-two sizes an out-of-range index can appear here; the
    // top masks the result with its own address check.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_regs.sv
// ---------------------------------------------------------------------------
// apb_slave_regs
// APB slave exposing NUM_REGS 32-bit registers with WAIT_STATES extra
// access-phase cycles per transfer. Out-of-range accesses complete with
// pslverr. wr_count counts successful writes and saturates at 16'hFFFF.
//
// Ports:
//   pclk      in   clock, rising edge
//   presetn   in   asynchronous active-low reset
//   psel      in   APB select
//   penable   in   APB access-phase strobe
//   pwrite    in   1 = write, 0 = read
//   paddr     in   word index
//   pwdata    in   write data (sampled in the setup phase only)
//   prdata    out  read data, 0 unless a valid read is completing
//   pready    out  transfer complete (combinational)
//   pslverr   out  error response, only while pready=1
//   wr_count  out  saturating count of successful writes
// ---------------------------------------------------------------------------
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [15:0]           wr_count
);

    localparam int                  IDX_W      = idx_width(NUM_REGS);
    // One extra bit so NUM_REGS=256 is representable in the range check.
    localparam logic [APB_ADDR_W:0] NUM_REGS_C = (APB_ADDR_W + 1)'(NUM_REGS);
    localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_STATES);

    apb_state_e            r_state;
    logic [3:0]            r_cnt;
    logic [APB_ADDR_W-1:0] r_addr;
    logic                  r_write;
    logic [APB_DATA_W-1:0] r_wdata;
    logic [15:0]           r_wr_count;

    logic                  w_addr_ok;
    logic                  w_ready;
    logic                  w_we;
    logic [IDX_W-1:0]      w_idx;
    logic [APB_DATA_W-1:0] w_rdata;

    assign w_addr_ok = ({1'b0, r_addr} < NUM_REGS_C);
    assign w_ready   = (r_state == ACCESS) && (r_cnt == 4'd0) && psel && penable;
    assign w_we      = w_ready && r_write && w_addr_ok;
    assign w_idx     = r_addr[IDX_W-1:0];

    assign pready   = w_ready;
    assign pslverr  = w_ready && !w_addr_ok;
    assign prdata   = (w_ready && !r_write && w_addr_ok) ? w_rdata : '0;
    assign wr_count = r_wr_count;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // psel with penable already high is a protocol
                    // violation and is deliberately not treated as setup.
                    if (psel && !penable) begin
                        r_addr  <= paddr;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        r_cnt   <= WAIT_INIT;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        r_state <= IDLE;          // master aborted
                    end else if (penable) begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_state <= IDLE;      // completion edge
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_count <= '0;
        end else if (w_we && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    apb_slave_regs_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .pclk    (pclk),
        .presetn (presetn),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 16, giving the number of 32-bit registers (1..256).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the extra access-phase cycles before pready (0..15).
REQ-003 pclk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 presetn  input  1  reset, asynchronous, active-low.
REQ-005 psel  input  1  APB select from the upstream master.
REQ-006 penable  input  1  APB access-phase strobe.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  word index; increments by 1 per register.
REQ-009 pwdata  input  32  write data.
REQ-010 prdata  output  32  read data.
REQ-011 pready  output  1  transfer-complete indication.
REQ-012 pslverr  output  1  error response, valid only while pready=1.
REQ-013 wr_count  output  16  number of successful writes, saturating.

Function
REQ-014 The FSM SHALL have two states, IDLE and ACCESS.
REQ-015 In IDLE, a rising edge with psel=1 and penable=0 SHALL capture paddr, pwrite and pwdata, load wait counter cnt=WAIT_STATES, and enter ACCESS.
REQ-016 In IDLE, psel=1 with penable=1 (protocol violation) SHALL be ignored: state stays IDLE and pready=0.
REQ-017 In ACCESS, each edge with psel=1, penable=1 and cnt!=0 SHALL decrement cnt.
REQ-018 pready SHALL be combinational: 1 only when state=ACCESS, cnt=0, psel=1 and penable=1; otherwise 0.
REQ-019 Latency: a transfer SHALL occupy exactly 2+WAIT_STATES cycles from setup to completion edge inclusive; WAIT_STATES=0 gives pready in the first access cycle.
REQ-020 The completion edge is the edge with psel=penable=pready=1; on it, state SHALL return to IDLE.
REQ-021 An address is valid when the captured address is less than NUM_REGS.
REQ-022 Write, valid address: on the completion edge, reg[addr] SHALL be set to the captured pwdata and wr_count SHALL increment, holding at 16'hFFFF.
REQ-023 Write, invalid address: no register or wr_count SHALL change, and pslverr SHALL be 1 while pready=1.
REQ-024 Read, valid address: prdata SHALL equal reg[addr] while pready=1.
REQ-025 Read, invalid address: prdata SHALL be 0 and pslverr SHALL be 1 while pready=1.
REQ-026 prdata and pslverr SHALL be 0 whenever pready=0.
REQ-027 psel dropping in ACCESS before completion SHALL abort the transfer: return to IDLE with no register or count update.
REQ-028 A new setup phase on the cycle immediately after a completion edge SHALL be accepted (back-to-back transfers).
REQ-029 pwdata changing during ACCESS SHALL have no effect; the value captured in setup is written.

Reset
REQ-030 presetn=0 SHALL immediately force state=IDLE, cnt=0, all registers=0 and wr_count=0, with pready, pslverr and prdata at 0.
REQ-031 Reset asserted mid-transfer SHALL discard that transfer with no register update.
REQ-032 The first setup phase SHALL be accepted on the first rising edge after presetn deasserts.

Structure
REQ-033 Shared package apb_pkg SHALL hold the state enum (IDLE, ACCESS) and the constants APB_ADDR_W=8 and APB_DATA_W=32.
REQ-034 Storage SHALL be the sub-module apb_slave_regs_bank: NUM_REGS x 32 flops with one synchronous write port, one asynchronous read port, and async reset to 0.
REQ-035 FSM, wait counter, decode and wr_count SHALL reside in apb_slave_regs.

Verification
REQ-036 WAIT_STATES=2: write 0xDEADBEEF to addr 3 -> pready high in the 3rd access cycle, pslverr=0, reg[3]=0xDEADBEEF, wr_count=1.
REQ-037 After REQ-036, read addr 3 -> prdata=0xDEADBEEF with pready, then 0 afterwards.
REQ-038 Write 0x12345678 to addr 0x20 (NUM_REGS=16) -> pslverr=1 with pready, no register changes, wr_count unchanged; a read of 0x20 returns prdata=0 with pslverr=1.
REQ-039 Upstream master stream: writes to addrs 0..17 with data=addr -> regs 0..15 hold 0..15, addrs 16..17 return errors, wr_count=16.
REQ-040 WAIT_STATES=0, back-to-back writes -> pready in the first access cycle; presetn pulsed in ACCESS of a write to addr 5 -> reg[5]=0 and the next transfer completes normally.
REQ-041 psel dropped mid-wait on a write to addr 2 -> no update; with wr_count preloaded to 0xFFFF by 65535 writes, a further valid write -> wr_count stays 0xFFFF.
